// File: rtl/light_sequencer_if.sv
// light_sequencer_if: signal bundle between the light sequencer and the light block plus its timing/request logic
interface light_sequencer_if;
  logic       enable;
  logic       ped_req;
  logic [2:0] light;
  logic       sel;
  logic       button;
  logic       ped_ack;
  logic [2:0] phase;
  logic       fault;
  modport master (input enable, ped_req, light, output sel, button, ped_ack, phase, fault);
  modport slave (output enable, ped_req, light, input sel, button, ped_ack, phase, fault);
endinterface

// File: rtl/light_sequencer.sv
// light_sequencer: steps the light block through timed phases, verifies each returned code, serves pedestrian requests
module light_sequencer #(
  parameter int RED_CYCLES   = 8,
  parameter int RA_CYCLES    = 2,
  parameter int GREEN_CYCLES = 8,
  parameter int AMBER_CYCLES = 3,
  parameter int PED_CYCLES   = 4,
  parameter int SYNC_MAX     = 8,
  parameter int CNT_W        = 8
) (
  input  logic              clk,
  input  logic              rst,
  light_sequencer_if.master seq_if
);
  typedef enum logic [2:0] {SYNC = 3'd0, RED = 3'd1, RA = 3'd2, GREEN = 3'd3, AMBER = 3'd4, FAULT = 3'd7} state_t;
  localparam int PW = $clog2(SYNC_MAX + 1);
  localparam logic [2:0] C_RED = 3'b100, C_RA = 3'b110, C_GREEN = 3'b001, C_AMBER = 3'b010;
  localparam logic [CNT_W-1:0] L_RED = CNT_W'(RED_CYCLES - 1);
  localparam logic [CNT_W-1:0] L_PED = CNT_W'(RED_CYCLES + PED_CYCLES - 1);
  localparam logic [CNT_W-1:0] L_RA = CNT_W'(RA_CYCLES - 1);
  localparam logic [CNT_W-1:0] L_GREEN = CNT_W'(GREEN_CYCLES - 1);
  localparam logic [CNT_W-1:0] L_AMBER = CNT_W'(AMBER_CYCLES - 1);
  localparam logic [PW-1:0] P_MAX = PW'(SYNC_MAX);
  state_t state_q, state_d, next_ph;
  logic [CNT_W-1:0] cnt_q, cnt_d, load;
  logic [PW-1:0] pulses_q, pulses_d;
  logic chk_q, chk_d, first_q, first_d, pend_q, pend_d, ack_q, ack_d, sel_q;
  logic in_phase, mismatch, step, sync_hit, serve;
  logic [2:0] code;
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= SYNC;
      cnt_q    <= '0;
      pulses_q <= '0;
      chk_q    <= 1'b1;
      first_q  <= 1'b0;
      pend_q   <= 1'b0;
      ack_q    <= 1'b0;
      sel_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      pulses_q <= pulses_d;
      chk_q    <= chk_d;
      first_q  <= first_d;
      pend_q   <= pend_d;
      ack_q    <= ack_d;
      sel_q    <= 1'b1;
    end
  end
  // SYNC alternates check/pulse starting with a check, so the first cycle after reset never steps the block
  always_comb begin
    in_phase = state_q inside {RED, RA, GREEN, AMBER};
    code     = state_q == RED ? C_RED : state_q == RA ? C_RA : state_q == GREEN ? C_GREEN : C_AMBER;
    next_ph  = state_q == RED ? RA : state_q == RA ? GREEN : state_q == GREEN ? AMBER : RED;
    mismatch = in_phase && first_q && seq_if.light != code;
    step     = in_phase && !mismatch && cnt_q == '0 && seq_if.enable;
    sync_hit = state_q == SYNC && chk_q && seq_if.light == C_RED;
    serve    = (step && state_q == AMBER && (pend_q || seq_if.ped_req)) || (sync_hit && pend_q);
    load     = next_ph == RA ? L_RA : next_ph == GREEN ? L_GREEN : next_ph == AMBER ? L_AMBER :
               serve ? L_PED : L_RED;
    state_d  = state_q;
    cnt_d    = cnt_q;
    pulses_d = pulses_q;
    chk_d    = chk_q;
    first_d  = 1'b0;
    ack_d    = serve;
    pend_d   = serve ? 1'b0 : pend_q | (in_phase & seq_if.ped_req);
    if (state_q == SYNC) begin
      chk_d    = !chk_q;
      pulses_d = chk_q ? pulses_q : pulses_q + 1'b1;
      state_d  = sync_hit ? RED : (chk_q && pulses_q == P_MAX) ? FAULT : SYNC;
      cnt_d    = sync_hit ? load : cnt_q;
    end else if (mismatch) begin
      state_d = FAULT;
    end else if (step) begin
      state_d = next_ph;
      cnt_d   = load;
      first_d = 1'b1;
    end else if (in_phase && seq_if.enable) begin
      cnt_d = cnt_q - 1'b1;
    end
  end
  assign seq_if.sel     = sel_q;
  assign seq_if.button  = state_q == SYNC ? !chk_q : step;
  assign seq_if.ped_ack = ack_q;
  assign seq_if.phase   = state_q;
  assign seq_if.fault   = state_q == FAULT;
endmodule
